// File: rtl/hysteresis_nbr_buffer_if.sv
// Handshake and data bundle between the pixel source, the neighbour buffer
// and the combinational hysteresis classifier.
interface hysteresis_nbr_buffer_if;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_mag;
    logic [1:0]      in_angle;
    logic [4:0][7:0] grad_out_mag;
    logic [1:0]      grad_out_angle;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      edge_in;
    logic            frame_done;
    logic [15:0]     edge_count;

    modport slave (
        input  in_valid, in_mag, in_angle, out_ready, edge_in,
        output in_ready, grad_out_mag, grad_out_angle, out_valid, frame_done, edge_count
    );

    modport master (
        output in_valid, in_mag, in_angle, out_ready, edge_in,
        input  in_ready, grad_out_mag, grad_out_angle, out_valid, frame_done, edge_count
    );
endinterface

// File: rtl/hysteresis_nbr_buffer.sv
// Neighbour-assembly stage ahead of the hysteresis classifier.
// Holds one pixel in an output register, and builds its causal neighbours
// (left, up-left, up, up-right) from a one-row buffer of edge decisions.
// Optional feature: define HYST_EDGE_COUNT_EN to count edge pixels per frame;
// otherwise edge_count reads as zero.
module hysteresis_nbr_buffer #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input logic                   clk,
    input logic                   n_rst,
    hysteresis_nbr_buffer_if.slave bus
);
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic                 r_valid;
    logic [7:0]           r_mag;
    logic [1:0]           r_angle;
    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    logic [IMG_WIDTH-1:0] r_line;
    logic                 r_left;
    logic                 r_ul;
    logic                 r_frame_done;

    logic          w_in_hs;
    logic          w_out_hs;
    logic          w_e;
    logic          w_col_first;
    logic          w_col_last;
    logic          w_row_first;
    logic          w_frame_end;
    logic [CW-1:0] w_ur_idx;
    logic [7:0]    w_left;
    logic [7:0]    w_ul;
    logic [7:0]    w_up;
    logic [7:0]    w_ur;

    assign bus.in_ready = !r_valid || bus.out_ready;
    assign w_in_hs      = bus.in_valid && bus.in_ready;
    assign w_out_hs     = r_valid && bus.out_ready;
    assign w_e          = (bus.edge_in == 8'hFF);

    assign w_col_first  = (r_col == '0);
    assign w_col_last   = (r_col == COL_LAST);
    assign w_row_first  = (r_row == '0);
    assign w_frame_end  = w_col_last && (r_row == ROW_LAST);

    // Last column never reads past the buffer; its up-right is masked anyway.
    assign w_ur_idx = w_col_last ? r_col : r_col + 1'b1;

    assign w_left = w_col_first                  ? 8'h00 : {8{r_left}};
    assign w_ul   = (w_row_first || w_col_first) ? 8'h00 : {8{r_ul}};
    assign w_up   = w_row_first                  ? 8'h00 : {8{r_line[r_col]}};
    assign w_ur   = (w_row_first || w_col_last)  ? 8'h00 : {8{r_line[w_ur_idx]}};

    assign bus.grad_out_mag   = {r_mag, w_left, w_ul, w_up, w_ur};
    assign bus.grad_out_angle = r_angle;
    assign bus.out_valid      = r_valid;
    assign bus.frame_done     = r_frame_done;

    // Output register: load on input handshake, empty on a lone output handshake.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_valid <= 1'b0;
            r_mag   <= 8'h00;
            r_angle <= 2'd0;
        end else if (w_in_hs) begin
            r_valid <= 1'b1;
            r_mag   <= bus.in_mag;
            r_angle <= bus.in_angle;
        end else if (w_out_hs) begin
            r_valid <= 1'b0;
        end
    end

    // Neighbour state: up-left takes the old row value before it is overwritten.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_line <= '0;
            r_left <= 1'b0;
            r_ul   <= 1'b0;
        end else if (w_out_hs) begin
            r_ul          <= r_line[r_col];
            r_line[r_col] <= w_e;
            r_left        <= w_e;
        end
    end

    // Raster position of the pixel being presented (or the next one to arrive).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_out_hs) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // One-cycle pulse after the final pixel of a frame leaves.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_out_hs && w_frame_end;
        end
    end

`ifdef HYST_EDGE_COUNT_EN
    logic [15:0] r_edge_acc;
    logic [15:0] r_edge_count;
    logic [15:0] w_acc_next;

    assign w_acc_next = (w_out_hs && w_e && (r_edge_acc != 16'hFFFF)) ?
                        r_edge_acc + 16'd1 : r_edge_acc;
    assign bus.edge_count = r_edge_count;

    // Saturating per-frame edge tally; the total includes the frame's last pixel.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_edge_acc   <= 16'h0000;
            r_edge_count <= 16'h0000;
        end else if (w_out_hs && w_frame_end) begin
            r_edge_count <= w_acc_next;
            r_edge_acc   <= 16'h0000;
        end else begin
            r_edge_acc   <= w_acc_next;
        end
    end
`else
    assign bus.edge_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hysteresis_nbr_buffer.sv
// Scoreboard bench: the driver pushes the expected window of each pixel it
// issues; a monitor on the falling edge pops and compares whatever the DUT
// presents, and supplies the classifier result for it.
module tb_hysteresis_nbr_buffer;
    localparam int W = 16;
    localparam int H = 16;

    typedef struct packed {
        logic [7:0]  mag;
        logic [1:0]  ang;
        logic [31:0] nbr;
        logic        e;
    } exp_t;

    logic clk;
    logic n_rst;
    logic stall;
    int   tests;
    int   fails;
    int   fd_seen;
    exp_t q[$];
    logic [15:0] fq[$];

    hysteresis_nbr_buffer_if bus();

    hysteresis_nbr_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Edge decisions used per frame: 0 = frame A (37 edges), 1 = frame B, 2 = frame C (2 edges).
    function automatic bit emap(input int f, input int r, input int c);
        case (f)
            0: begin
                if (r == 0) return (c == 2) || (c == 4) || (c == 6);
                return (c == 0) || (c == 15) || (r == 5 && c >= 3 && c <= 6);
            end
            1: return (r == 1 && c == 1) || (r == 2 && c == 2) || (r == 6 && c == 9);
            default: return (r == 0 && c == 1) || (r == 3 && c == 3);
        endcase
    endfunction

    task automatic send_pixel(input exp_t x);
        bit done;
        done = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_mag   = x.mag;
        bus.in_angle = x.ang;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (bus.in_ready) begin
                q.push_back(x);
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input int f, input int npix, input logic [15:0] expcnt);
        exp_t x;
        int r, c;
        logic [7:0] l, ul, up, ur;
        for (int p = 0; p < npix; p++) begin
            r = p / W;
            c = p % W;
            l  = (c > 0 && emap(f, r, c - 1))              ? 8'hFF : 8'h00;
            ul = (r > 0 && c > 0 && emap(f, r - 1, c - 1)) ? 8'hFF : 8'h00;
            up = (r > 0 && emap(f, r - 1, c))              ? 8'hFF : 8'h00;
            ur = (r > 0 && c < W - 1 && emap(f, r - 1, c + 1)) ? 8'hFF : 8'h00;
            x.mag = 8'(p + 32);
            x.ang = 2'(r + c);
            x.nbr = {l, ul, up, ur};
            x.e   = emap(f, r, c);
            if (p == W * H - 1) fq.push_back(expcnt);
            if (p == 100) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                repeat (2) @(negedge clk);
            end
            send_pixel(x);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   64'(bus.in_ready),       64'd1);
        check({tag, "_out_valid"},  64'(bus.out_valid),      64'd0);
        check({tag, "_grad_mag"},   64'(bus.grad_out_mag),   64'd0);
        check({tag, "_grad_angle"}, 64'(bus.grad_out_angle), 64'd0);
        check({tag, "_frame_done"}, 64'(bus.frame_done),     64'd0);
        check({tag, "_edge_count"}, 64'(bus.edge_count),     64'd0);
    endtask

    // Monitor: compare every presented window, supply edge_in, pop on handshake.
    initial begin
        bus.out_ready = 1'b0;
        bus.edge_in   = 8'h00;
        forever begin
            @(negedge clk);
            bus.out_ready = !stall;
            if (n_rst && bus.out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_window", 64'(bus.grad_out_mag), 64'd0);
                    bus.edge_in = 8'h00;
                end else begin
                    check("window", 64'(bus.grad_out_mag), {24'd0, q[0].mag, q[0].nbr});
                    check("angle",  64'(bus.grad_out_angle), 64'(q[0].ang));
                    bus.edge_in = q[0].e ? 8'hFF : 8'hFE;
                    if (bus.out_ready) void'(q.pop_front());
                end
            end else begin
                bus.edge_in = 8'h00;
            end
            if (n_rst && bus.frame_done) begin
                fd_seen++;
                if (fq.size() == 0) check("unexpected_frame_done", 64'd1, 64'd0);
                else check("edge_count", 64'(bus.edge_count), 64'(fq.pop_front()));
            end
        end
    end

    initial begin
        logic [15:0] cnt_a, cnt_c;
        tests = 0;
        fails = 0;
        fd_seen = 0;
        stall = 1'b0;
`ifdef HYST_EDGE_COUNT_EN
        cnt_a = 16'd37;
        cnt_c = 16'd2;
`else
        cnt_a = 16'd0;
        cnt_c = 16'd0;
`endif
        n_rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_mag   = 8'h20;
        bus.in_angle = 2'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;

        // Frame A with a three-cycle backpressure window in the middle.
        fork
            send_frame(0, W * H, cnt_a);
            begin
                repeat (50) @(posedge clk);
                stall = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    #2;
                    check("bp_in_ready",  64'(bus.in_ready),  64'd0);
                    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
                end
                @(posedge clk);
                stall = 1'b0;
            end
        join

        // Frame B interrupted by reset right after pixel (7,9) is accepted.
        send_frame(1, 7 * W + 10, 16'd0);
        #1;
        n_rst = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_mid");
        #1;
        n_rst = 1'b1;

        // Frame C must start again at (0,0) and end with exactly one frame_done.
        send_frame(2, W * H, cnt_c);

        for (int k = 0; k < 500 && q.size() != 0; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("drain_empty",     64'(q.size()),  64'd0);
        check("frame_done_count", 64'(fd_seen),  64'd2);
        check("frame_q_empty",   64'(fq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
